line_clear_ctrl: RTL and testbench

Sequential line-clear engine that runs between the PLACE step and the next brick spawn in the game FSM.
- Captures the placed-brick board on a start pulse.
- Scans rows bottom-to-top, one row per cycle; collapses each full row with a one-cycle shift.
- Returns the compacted board, the number of lines cleared, and a running line total for scoring.
- Replaces the free-running combinational clear path with a handshaked, cycle-defined sequence.

---
 rtl/line_clear_ctrl.sv | 155 +++++++++++++++
 tb/tb_line_clear_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: sequential line-clear engine run after a brick is placed.
// Captures the board on start, scans rows bottom-to-top one per cycle,
// collapses each full row with a one-cycle shift, then reports the
// compacted board, the per-operation clear count and a running total.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SCAN  | test work row `row` for fullness
// SHIFT | drop every row above `row` by one, empty row enters at the top
// DONE  | one-cycle done pulse; results publish on the exiting edge

module line_clear_ctrl #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int CELL_W = 3,
    parameter int CNT_W  = 3,
    parameter int TOT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ROWS*COLS*CELL_W-1:0]   board_in,
    output logic                          busy,
    output logic                          done,
    output logic [ROWS*COLS*CELL_W-1:0]   board_out,
    output logic [CNT_W-1:0]              num_cleared,
    output logic [TOT_W-1:0]              lines_total
);

    localparam int ROW_W   = COLS * CELL_W;
    localparam int BOARD_W = ROWS * ROW_W;
    localparam int RIDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    // k must count up to ROWS shifts exactly, independent of CNT_W saturation
    localparam int K_W     = $clog2(ROWS + 1);

    localparam logic [RIDX_W-1:0] ROW_LAST = RIDX_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [BOARD_W-1:0]   work_q;
    logic [RIDX_W-1:0]    row_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [K_W-1:0]       k_q;
    logic                 busy_q;
    logic                 done_q;
    logic [BOARD_W-1:0]   board_out_q;
    logic [CNT_W-1:0]     num_cleared_q;
    logic [TOT_W-1:0]     lines_total_q;

    logic [ROW_W-1:0]     row_bits;
    logic                 row_full;
    logic [BOARD_W-1:0]   work_shift_d;
    logic [CNT_W-1:0]     cnt_inc_d;

    // Full-row detect on the row currently pointed at by the scan index
    always_comb begin
        row_bits = work_q[int'(row_q) * ROW_W +: ROW_W];
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row_bits[c * CELL_W +: CELL_W] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    // Collapsed board: rows at and above the scan index move down one
    always_comb begin
        work_shift_d = work_q;
        for (int i = 0; i < ROWS - 1; i++) begin
            if (i >= int'(row_q)) begin
                work_shift_d[i * ROW_W +: ROW_W] = work_q[(i + 1) * ROW_W +: ROW_W];
            end
        end
        work_shift_d[(ROWS - 1) * ROW_W +: ROW_W] = '0;
    end

    // Reported count saturates; the true count lives in k_q
    always_comb begin
        cnt_inc_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Sequencer with registered busy/done and published results
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            work_q        <= '0;
            row_q         <= '0;
            cnt_q         <= '0;
            k_q           <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            board_out_q   <= '0;
            num_cleared_q <= '0;
            lines_total_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        work_q  <= board_in;
                        row_q   <= '0;
                        cnt_q   <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (row_full) begin
                        state_q <= S_SHIFT;
                    end else if (row_q == ROW_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // row_q is kept so a full row falling into place is rescanned
                    work_q  <= work_shift_d;
                    cnt_q   <= cnt_inc_d;
                    k_q     <= k_q + 1'b1;
                    state_q <= S_SCAN;
                end
                S_DONE: begin
                    board_out_q   <= work_q;
                    num_cleared_q <= cnt_q;
                    lines_total_q <= lines_total_q + TOT_W'(k_q);
                    done_q        <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign board_out   = board_out_q;
    assign num_cleared = num_cleared_q;
    assign lines_total = lines_total_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: directed boards plus random boards, checked
// against a row-filtering model of the clear operation.

module tb_line_clear_ctrl;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int CELL_W = 3;
    localparam int CNT_W  = 3;
    localparam int TOT_W  = 16;
    localparam int BW     = ROWS * COLS * CELL_W;
    localparam int CNT_MAXV = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic [BW-1:0]     board_in;
    logic              busy;
    logic              done;
    logic [BW-1:0]     board_out;
    logic [CNT_W-1:0]  num_cleared;
    logic [TOT_W-1:0]  lines_total;

    int n_cmp = 0;
    int n_err = 0;
    int exp_total = 0;

    line_clear_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CNT_W(CNT_W), .TOT_W(TOT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .board_in(board_in),
        .busy(busy),
        .done(done),
        .board_out(board_out),
        .num_cleared(num_cleared),
        .lines_total(lines_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] with_cell(input logic [BW-1:0] b, input int r, input int c, input int v);
        logic [BW-1:0] t;
        t = b;
        t[(r * COLS + c) * CELL_W +: CELL_W] = CELL_W'(v);
        return t;
    endfunction

    function automatic logic [BW-1:0] with_full_row(input logic [BW-1:0] b, input int r, input int v);
        logic [BW-1:0] t;
        t = b;
        for (int c = 0; c < COLS; c++) t[(r * COLS + c) * CELL_W +: CELL_W] = CELL_W'(v);
        return t;
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] t;
        t = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int c = 0; c < COLS; c++) t[(r * COLS + c) * CELL_W +: CELL_W] = CELL_W'($urandom_range(1, 7));
            end else begin
                for (int c = 0; c < COLS; c++)
                    t[(r * COLS + c) * CELL_W +: CELL_W] = ($urandom_range(0, 3) == 0) ? '0 : CELL_W'($urandom_range(1, 7));
            end
        end
        return t;
    endfunction

    // Model: remove every full row, keep the others in order from the bottom.
    task automatic model(input logic [BW-1:0] b, output logic [BW-1:0] out, output int k);
        int cells [ROWS][COLS];
        int dst;
        bit full;
        out = '0;
        k   = 0;
        dst = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                cells[r][c] = int'(b[(r * COLS + c) * CELL_W +: CELL_W]);
        for (int r = 0; r < ROWS; r++) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (cells[r][c] == 0) full = 1'b0;
            if (full) begin
                k++;
            end else begin
                for (int c = 0; c < COLS; c++)
                    out[(dst * COLS + c) * CELL_W +: CELL_W] = CELL_W'(cells[r][c]);
                dst++;
            end
        end
    endtask

    // One operation; optionally re-pulse start at a given cycle and/or during DONE.
    task automatic run_op(input string tag, input logic [BW-1:0] b, input int restart_at, input bit pulse_in_done);
        logic [BW-1:0] exp_out;
        logic [BW-1:0] junk;
        int k, exp_lat, done_at, done_cnt, busy_cycles;
        model(b, exp_out, k);
        exp_lat = ROWS + 2 * k + 1;
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < BW; i++) junk[i] = 1'($urandom_range(0, 1));
        board_in    = junk;
        done_at     = 0;
        done_cnt    = 0;
        busy_cycles = 0;
        for (int n = 1; n <= 4 * ROWS + 10; n++) begin
            if (n > 1) @(negedge clk);
            start = (n == restart_at) || (pulse_in_done && done === 1'b1);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (done_at != 0 && n >= done_at + 3) break;
        end
        start = 1'b0;
        exp_total = (exp_total + k) % (1 << TOT_W);
        chk({tag, " done_cycle"}, BW'(done_at), BW'(exp_lat));
        chk({tag, " done_pulses"}, BW'(done_cnt), BW'(1));
        chk({tag, " busy_cycles"}, BW'(busy_cycles), BW'(exp_lat));
        chk({tag, " board_out"}, board_out, exp_out);
        chk({tag, " num_cleared"}, BW'(num_cleared), BW'((k > CNT_MAXV) ? CNT_MAXV : k));
        chk({tag, " lines_total"}, BW'(lines_total), BW'(exp_total));
    endtask

    initial begin
        logic [BW-1:0] b;
        int dcnt;
        rst      = 1'b0;
        start    = 1'b0;
        board_in = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", BW'(busy), '0);
        chk("rst done", BW'(done), '0);
        chk("rst board_out", board_out, '0);
        chk("rst num_cleared", BW'(num_cleared), '0);
        chk("rst lines_total", BW'(lines_total), '0);
        rst = 1'b1;

        run_op("empty", '0, 0, 1'b0);

        b = with_full_row('0, 0, 1);
        b = with_cell(b, 1, 0, 5);
        run_op("row0", b, 0, 1'b0);

        b = '0;
        for (int r = 0; r < 4; r++) b = with_full_row(b, r, r + 1);
        b = with_cell(b, 4, 9, 2);
        run_op("rows0to3", b, 0, 1'b0);

        b = with_full_row('0, 2, 3);
        b = with_full_row(b, 5, 6);
        b = with_cell(b, 3, 3, 7);
        b = with_cell(b, 6, 4, 1);
        run_op("rows2and5", b, 0, 1'b0);

        b = with_full_row('0, ROWS - 1, 4);
        b = with_cell(b, 0, 2, 6);
        run_op("toprow", b, 0, 1'b0);

        b = '0;
        for (int r = 0; r < ROWS; r++) b = with_full_row(b, r, (r % 7) + 1);
        run_op("allfull_sat", b, 0, 1'b0);

        b = '0;
        for (int r = 3; r < 12; r++) b = with_full_row(b, r, 2);
        b = with_cell(b, 12, 1, 3);
        run_op("nine_sat", b, 0, 1'b0);

        b = with_full_row('0, 1, 5);
        b = with_cell(b, 2, 7, 4);
        run_op("repulse", b, 6, 1'b1);

        // reset in the middle of a scan abandons the operation
        b = with_full_row('0, 8, 3);
        @(negedge clk);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst busy", BW'(busy), '0);
        chk("midrst done", BW'(done), '0);
        chk("midrst board_out", board_out, '0);
        chk("midrst lines_total", BW'(lines_total), '0);
        rst = 1'b1;
        exp_total = 0;
        dcnt = 0;
        repeat (3 * ROWS) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        chk("midrst no_done", BW'(dcnt), '0);

        b = with_full_row('0, 0, 7);
        b = with_cell(b, 5, 5, 5);
        run_op("after_rst", b, 0, 1'b0);

        for (int t = 0; t < 15; t++) begin
            b = rand_board();
            run_op($sformatf("rand%0d", t), b, (t % 3 == 0) ? int'($urandom_range(2, 15)) : 0, (t % 4 == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
